// File: rtl/golden_core.sv
// Single-cycle RV32I integer core: fetch, decode, execute and retire one
// instruction per clock against a combinational ROM and a clocked-write RAM.
module golden_core #(
    parameter int ADDR_WIDTH = 10,
    parameter int SIZE       = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [SIZE-1:0]       idata,
    output logic [ADDR_WIDTH-1:0] iaddr,
    output logic [ADDR_WIDTH-1:0] daddr,
    input  logic [SIZE-1:0]       ddata_r,
    output logic [SIZE-1:0]       ddata_w,
    output logic                  d_rw
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [SIZE-1:0] pc_q, pc_d;
    logic [SIZE-1:0] rf_q [32];

    logic [6:0]      opc;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [SIZE-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [SIZE-1:0] rs1_v, rs2_v;
    logic [SIZE-1:0] pc_4, mem_addr, jalr_sum, wb_val;
    logic            wb_en, st_en, br_take, imm_ok, reg_ok;
    logic            unused_mem;

    assign opc = idata[6:0];
    assign rd  = idata[11:7];
    assign f3  = idata[14:12];
    assign rs1 = idata[19:15];
    assign rs2 = idata[24:20];
    assign f7  = idata[31:25];

    assign imm_i = {{20{idata[31]}}, idata[31:20]};
    assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
    assign imm_b = {{19{idata[31]}}, idata[31], idata[7],
                    idata[30:25], idata[11:8], 1'b0};
    assign imm_u = {idata[31:12], 12'b0};
    assign imm_j = {{11{idata[31]}}, idata[31], idata[19:12],
                    idata[20], idata[30:21], 1'b0};

    assign rs1_v = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_v = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    function automatic logic [SIZE-1:0] alu(
        input logic [SIZE-1:0] a,
        input logic [SIZE-1:0] b,
        input logic [2:0]      op,
        input logic            alt
    );
        unique case (op)
            3'b000: alu = alt ? a - b : a + b;
            3'b001: alu = a << b[4:0];
            3'b010: alu = {{(SIZE-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011: alu = {{(SIZE-1){1'b0}}, a < b};
            3'b100: alu = a ^ b;
            3'b101: alu = alt ? $unsigned($signed(a) >>> b[4:0])
                              : a >> b[4:0];
            3'b110: alu = a | b;
            3'b111: alu = a & b;
        endcase
    endfunction

    always_comb begin
        br_take = 1'b0;
        unique case (f3)
            3'b000:  br_take = rs1_v == rs2_v;
            3'b001:  br_take = rs1_v != rs2_v;
            3'b100:  br_take = $signed(rs1_v) < $signed(rs2_v);
            3'b101:  br_take = $signed(rs1_v) >= $signed(rs2_v);
            3'b110:  br_take = rs1_v < rs2_v;
            3'b111:  br_take = rs1_v >= rs2_v;
            default: br_take = 1'b0;
        endcase
    end

    // Reserved funct7 patterns fall through to NOP behaviour.
    assign imm_ok = (f3 == 3'b001) ? (f7 == 7'b0000000)
                  : (f3 == 3'b101) ? (f7 == 7'b0000000 || f7 == 7'b0100000)
                  : 1'b1;
    assign reg_ok = (f7 == 7'b0000000) ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));

    assign pc_4     = pc_q + 32'd4;
    assign jalr_sum = rs1_v + imm_i;

    always_comb begin
        pc_d     = pc_4;
        wb_en    = 1'b0;
        wb_val   = '0;
        st_en    = 1'b0;
        mem_addr = jalr_sum;
        unique case (opc)
            OP_LUI: begin
                wb_en  = 1'b1;
                wb_val = imm_u;
            end
            OP_AUIPC: begin
                wb_en  = 1'b1;
                wb_val = pc_q + imm_u;
            end
            OP_JAL: begin
                wb_en  = 1'b1;
                wb_val = pc_4;
                pc_d   = pc_q + imm_j;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    wb_en  = 1'b1;
                    wb_val = pc_4;
                    pc_d   = {jalr_sum[SIZE-1:1], 1'b0};
                end
            end
            OP_BR: begin
                if (br_take) pc_d = pc_q + imm_b;
            end
            OP_LD: begin
                if (f3 == 3'b010) begin
                    wb_en  = 1'b1;
                    wb_val = ddata_r;
                end
            end
            OP_ST: begin
                mem_addr = rs1_v + imm_s;
                st_en    = (f3 == 3'b010);
            end
            OP_IMM: begin
                if (imm_ok) begin
                    wb_en  = 1'b1;
                    wb_val = alu(rs1_v, imm_i, f3,
                                 f3 == 3'b101 && idata[30]);
                end
            end
            OP_REG: begin
                if (reg_ok) begin
                    wb_en  = 1'b1;
                    wb_val = alu(rs1_v, rs2_v, f3, idata[30]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q <= '0;
            for (int k = 0; k < 32; k++) rf_q[k] <= '0;
        end else begin
            pc_q <= pc_d;
            if (wb_en && rd != 5'd0) rf_q[rd] <= wb_val;
        end
    end

    assign iaddr   = pc_q[ADDR_WIDTH+1:2];
    assign daddr   = mem_addr[ADDR_WIDTH+1:2];
    assign ddata_w = rs2_v;
    // Gate with reset so a store under reset never reaches the RAM.
    assign d_rw    = st_en & RESET_N;

    assign unused_mem = ^{mem_addr[1:0], mem_addr[SIZE-1:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_golden_core.sv
// Bench for golden_core: ROM/RAM models, store scoreboard, directed
// instruction program and a bubble-sort program with a mid-run reset.
module tb_golden_core;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] idata;
    logic [9:0]  iaddr;
    logic [9:0]  daddr;
    logic [31:0] ddata_r;
    logic [31:0] ddata_w;
    logic        d_rw;

    logic [31:0] rom [1024];
    logic [31:0] ram [1024];

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
    } st_t;

    st_t sbq [$];
    int  checks = 0;
    int  errors = 0;
    int  set2 [8];

    golden_core #(.ADDR_WIDTH(10), .SIZE(32)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .idata   (idata),
        .iaddr   (iaddr),
        .daddr   (daddr),
        .ddata_r (ddata_r),
        .ddata_w (ddata_w),
        .d_rw    (d_rw)
    );

    assign idata   = rom[iaddr];
    assign ddata_r = ram[daddr];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3,
                                          int rd, int opc);
        logic [31:0] m, s, f, d, o;
        m = imm; s = rs1; f = f3; d = rd; o = opc;
        return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1,
                                          int f3, int rd);
        logic [31:0] g, t, s, f, d;
        g = f7; t = rs2; s = rs1; f = f3; d = rd;
        return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [31:0] m, t, s;
        m = imm; t = rs2; s = rs1;
        return {m[11:5], t[4:0], s[4:0], 3'b010, m[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1,
                                          int f3);
        logic [31:0] m, t, s, f;
        m = imm; t = rs2; s = rs1; f = f3;
        return {m[12], m[10:5], t[4:0], s[4:0], f[2:0],
                m[4:1], m[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(int imm, int rd, int opc);
        logic [31:0] m, d, o;
        m = imm; d = rd; o = opc;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] m, d;
        m = imm; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 7'h13);
    endfunction

    function automatic logic [31:0] lw(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 2, rd, 7'h03);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic exp_st(input int byte_addr, input logic [31:0] d);
        st_t e;
        e.a = 10'(byte_addr / 4);
        e.d = d;
        sbq.push_back(e);
    endtask

    // Step n cycles; stores land in the RAM model and, when sb is set,
    // are matched against the head of the scoreboard.
    task automatic run(input int n, input bit sb);
        st_t e;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            if (d_rw) begin
                if (sb) begin
                    checks++;
                    assert (sbq.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_store got=%h/%h exp=none",
                               daddr, ddata_w);
                    end
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("st_addr", 32'(daddr), 32'(e.a));
                        chk("st_data", ddata_w, e.d);
                    end
                end
                ram[daddr] = ddata_w;
            end
        end
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 1024; k++) begin
            rom[k] = 32'h0000_0013;
            ram[k] = '0;
        end
    endtask

    task automatic load_sort();
        rom[0]  = addi(1, 0, 256);
        rom[1]  = addi(2, 0, 7);
        rom[2]  = addi(3, 0, 0);
        rom[3]  = addi(4, 1, 0);
        rom[4]  = lw(5, 4, 0);
        rom[5]  = lw(6, 4, 4);
        rom[6]  = enc_b(12, 5, 6, 5);
        rom[7]  = enc_s(0, 6, 4);
        rom[8]  = enc_s(4, 5, 4);
        rom[9]  = addi(4, 4, 4);
        rom[10] = addi(3, 3, 1);
        rom[11] = enc_b(-28, 2, 3, 4);
        rom[12] = addi(2, 2, -1);
        rom[13] = enc_b(-44, 2, 0, 4);
        rom[14] = enc_j(0, 0);
    endtask

    task automatic check_set2();
        int r [8];
        int t;
        r = set2;
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0 && r[j-1] > r[j]; j--) begin
                t = r[j]; r[j] = r[j-1]; r[j-1] = t;
            end
        end
        for (int k = 0; k < 8; k++) chk("sort2", ram[64+k], r[k]);
    endtask

    initial begin
        int set1 [8];
        int sorted1 [8];
        set1    = '{37, -5, 1000, 0, 32'h8000_0000, 12, 12, 7};
        sorted1 = '{32'h8000_0000, -5, 0, 7, 12, 12, 37, 1000};

        RESET_N = 1'b0;
        clear_mem();
        @(negedge CLK);
        chk("rst_iaddr", 32'(iaddr), 0);
        chk("rst_drw", 32'(d_rw), 0);
        RESET_N = 1'b1;
        chk("rel_iaddr0", 32'(iaddr), 0);
        @(negedge CLK);
        chk("rel_iaddr1", 32'(iaddr), 1);
        @(negedge CLK);
        chk("rel_iaddr2", 32'(iaddr), 2);

        RESET_N = 1'b0;
        #1;
        chk("async_rst_iaddr", 32'(iaddr), 0);

        clear_mem();
        rom[0]  = addi(1, 0, 5);
        rom[1]  = addi(2, 0, -3);
        rom[2]  = enc_r(0, 2, 1, 0, 3);
        rom[3]  = enc_r(32, 2, 1, 0, 4);
        rom[4]  = enc_r(0, 1, 2, 2, 5);
        rom[5]  = enc_r(0, 1, 2, 3, 6);
        rom[6]  = enc_s(8, 1, 0);
        rom[7]  = lw(7, 0, 8);
        rom[8]  = enc_s(16, 3, 0);
        rom[9]  = enc_s(20, 4, 0);
        rom[10] = enc_s(24, 5, 0);
        rom[11] = enc_s(28, 6, 0);
        rom[12] = enc_s(32, 7, 0);
        rom[13] = enc_b(8, 1, 1, 0);
        rom[14] = addi(9, 0, 1);
        rom[15] = enc_b(8, 1, 1, 1);
        rom[16] = addi(10, 0, 7);
        rom[17] = enc_s(36, 9, 0);
        rom[18] = enc_s(40, 10, 0);
        rom[19] = enc_j(12, 11);
        rom[20] = enc_s(44, 11, 0);
        rom[21] = enc_j(12, 0);
        rom[22] = addi(13, 0, 9);
        rom[23] = enc_i(0, 11, 0, 0, 7'h67);
        rom[24] = enc_s(48, 13, 0);
        rom[25] = enc_u(32'h12345, 8, 7'h37);
        rom[26] = enc_s(52, 8, 0);
        rom[27] = enc_u(1, 14, 7'h17);
        rom[28] = enc_s(56, 14, 0);
        rom[29] = addi(0, 0, 5);
        rom[30] = enc_s(60, 0, 0);
        rom[31] = enc_i(32'h401, 2, 5, 15, 7'h13);
        rom[32] = enc_s(64, 15, 0);
        rom[33] = enc_i(28, 2, 5, 16, 7'h13);
        rom[34] = enc_s(68, 16, 0);
        rom[35] = enc_i(-1, 1, 4, 17, 7'h13);
        rom[36] = enc_s(72, 17, 0);
        rom[37] = enc_r(0, 1, 1, 1, 18);
        rom[38] = enc_s(76, 18, 0);
        rom[39] = enc_b(8, 1, 2, 4);
        rom[40] = addi(19, 0, 1);
        rom[41] = enc_b(8, 1, 2, 6);
        rom[42] = addi(20, 0, 3);
        rom[43] = enc_s(80, 19, 0);
        rom[44] = enc_s(84, 20, 0);
        rom[45] = enc_j(0, 0);

        exp_st(8, 5);
        exp_st(16, 2);
        exp_st(20, 8);
        exp_st(24, 1);
        exp_st(28, 0);
        exp_st(32, 5);
        exp_st(36, 0);
        exp_st(40, 7);
        exp_st(44, 80);
        exp_st(48, 9);
        exp_st(52, 32'h1234_5000);
        exp_st(56, 32'h0000_106C);
        exp_st(60, 0);
        exp_st(64, 32'hFFFF_FFFE);
        exp_st(68, 32'h0000_000F);
        exp_st(72, 32'hFFFF_FFFA);
        exp_st(76, 160);
        exp_st(80, 0);
        exp_st(84, 3);

        @(negedge CLK);
        RESET_N = 1'b1;
        run(80, 1'b1);
        chk("missing_stores", sbq.size(), 0);
        chk("end_iaddr", 32'(iaddr), 45);

        RESET_N = 1'b0;
        clear_mem();
        load_sort();
        for (int k = 0; k < 8; k++) ram[64+k] = set1[k];
        @(negedge CLK);
        RESET_N = 1'b1;
        run(500, 1'b0);
        for (int k = 0; k < 8; k++) chk("sort1", ram[64+k], sorted1[k]);

        RESET_N = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set2[k]   = int'($urandom);
            ram[64+k] = set2[k];
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        run(60, 1'b0);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_iaddr", 32'(iaddr), 0);
        chk("mid_rst_drw", 32'(d_rw), 0);
        for (int k = 0; k < 8; k++) ram[64+k] = set2[k];
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("restart_iaddr", 32'(iaddr), 1);
        run(499, 1'b0);
        check_set2();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
